multicycle_control: RTL and testbench

- Multicycle control FSM for the 32-bit MIPS datapath; it is the initiator side of the ALU op interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects and the memory and register-file enables.
- Issues 4-bit ALU operation codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. It consumes the ALU zero flag for branches.

---
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, driving datapath selects and strobes.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t     cur_state;
    state_t     next_state;
    logic [3:0] funct_code;
    logic       funct_ok;
    logic [3:0] funct_code_q;

    // R-type funct to ALU operation code; funct_ok flags supported functs.
    always_comb begin
        funct_code = 4'd0;
        funct_ok   = 1'b1;
        case (funct)
            6'h24:   funct_code = 4'd0;
            6'h25:   funct_code = 4'd1;
            6'h20:   funct_code = 4'd2;
            6'h22:   funct_code = 4'd6;
            6'h2A:   funct_code = 4'd7;
            6'h27:   funct_code = 4'd12;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= S_IDLE;
            funct_code_q <= 4'd0;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_DECODE) begin
                funct_code_q <= funct_code;
            end
        end
    end

    assign state = cur_state;

    always_comb begin
        next_state = S_FETCH;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 4'd0;
        pc_src     = 2'd0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (cur_state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_read   = 1'b1;
                ir_write   = 1'b1;
                alu_src_b  = 2'd1;
                alu_op     = 4'd2;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here speculatively into ALUOut.
                alu_src_b = 2'd3;
                alu_op    = 4'd2;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) next_state = S_EXEC;
                        else          illegal    = 1'b1;
                    end
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_op     = 4'd2;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = funct_code_q;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 4'd6;
                pc_src     = 2'd1;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_op     = 4'd2;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction reference model
// pushes the expected control word of every cycle; a monitor pops and compares.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal, instr_done;
    logic [3:0] state;

    localparam int W = 23;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_vec;
    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    assign dut_vec = {state, pc_write, i_or_d, mem_read, mem_write, ir_write,
                      reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                      alu_op, pc_src, illegal, instr_done};

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ALU code and legality of an R-type funct.
    function automatic logic [3:0] rtype_code(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h20:   return 4'd2;
            6'h22:   return 4'd6;
            6'h2A:   return 4'd7;
            6'h27:   return 4'd12;
            default: begin ok = 1'b0; return 4'd0; end
        endcase
    endfunction

    // Expected control word of one step, taken from the per-state output list.
    function automatic logic [W-1:0] model_vec(input int st, input logic [3:0] code,
                                               input logic z, input logic ill);
        logic pcw, iod, mr, mw, irw, rd, m2r, rw, asa, il, dn;
        logic [1:0] asb, psrc;
        logic [3:0] aop;
        {pcw, iod, mr, mw, irw, rd, m2r, rw, asa, il, dn} = '0;
        asb = 2'd0; psrc = 2'd0; aop = 4'd0;
        case (st)
            1:  begin mr = 1; irw = 1; asb = 2'd1; aop = 4'd2; pcw = 1; end
            2:  begin asb = 2'd3; aop = 4'd2; il = ill; end
            3:  begin asa = 1; asb = 2'd2; aop = 4'd2; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; dn = 1; end
            6:  begin mw = 1; iod = 1; dn = 1; end
            7:  begin asa = 1; aop = code; end
            8:  begin rw = 1; rd = 1; dn = 1; end
            9:  begin asa = 1; aop = 4'd6; psrc = 2'd1; pcw = z; dn = 1; end
            10: begin psrc = 2'd2; pcw = 1; dn = 1; end
            11: begin asa = 1; asb = 2'd2; aop = 4'd2; end
            12: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {st[3:0], pcw, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, il, dn};
    endfunction

    // Driver: one instruction starting at FETCH; abort_at asserts rst during that step.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int abort_at);
        int seq[$];
        logic ok;
        logic [3:0] code;
        logic ill;
        logic aborted;
        code = rtype_code(fn, ok);
        ill = 1'b0;
        case (op)
            6'h23: seq = '{1, 2, 3, 4, 5};
            6'h2B: seq = '{1, 2, 3, 6};
            6'h04: seq = '{1, 2, 9};
            6'h02: seq = '{1, 2, 10};
            6'h08: seq = '{1, 2, 11, 12};
            6'h00: begin
                if (ok) seq = '{1, 2, 7, 8};
                else begin seq = '{1, 2}; ill = 1'b1; end
            end
            default: begin seq = '{1, 2}; ill = 1'b1; end
        endcase
        aborted = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) begin opcode = op; funct = fn; zero = z; end
            exp_q.push_back(model_vec(seq[i], code, z, ill));
            if (i == abort_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            @(posedge clk); #1;
            exp_q.push_back(model_vec(0, 4'd0, 1'b0, 1'b0));
            rst = 1'b0;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL ctrl_word t=%0t: got %h (state %0d) expected %h (state %0d)",
                         $time, dut_vec, state, e, e[W-1 -: 4]);
            end
            checks++;
            if ((mem_read && mem_write) || (reg_write && mem_write)) begin
                errors++;
                $display("FAIL strobe_exclusive t=%0t: mem_read=%b mem_write=%b reg_write=%b expected no overlap",
                         $time, mem_read, mem_write, reg_write);
            end
        end
    end

    initial begin
        logic [5:0] op, fn;
        logic [5:0] functs[6];
        int waited;
        functs = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
        rst = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp_q.push_back(model_vec(0, 4'd0, 1'b0, 1'b0));
        end
        rst = 1'b0;

        run_instr(6'h23, 6'h00, 1'b0, -1);
        run_instr(6'h00, 6'h22, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b1, -1);
        run_instr(6'h04, 6'h00, 1'b0, -1);
        run_instr(6'h3F, 6'h00, 1'b0, -1);
        run_instr(6'h00, 6'h01, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 2);
        run_instr(6'h02, 6'h00, 1'b0, -1);
        run_instr(6'h08, 6'h00, 1'b0, -1);
        foreach (functs[k]) run_instr(6'h00, functs[k], 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'h23;
                1: op = 6'h2B;
                2, 3: op = 6'h00;
                4: op = 6'h04;
                5: op = 6'h02;
                6: op = 6'h08;
                default: op = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
            else fn = functs[$urandom_range(0, 5)];
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 5) begin
            @(negedge clk); #1;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
